msp430_noc_link_buffer: RTL and testbench

Per-tile elastic flit buffer between a tile's NoC output (noc_out_*) and the mesh router input (in_*) of the 4D MPSoC.
- One independent FIFO per virtual channel, with last/valid/ready passthrough.
- Optional packet mode holds off the router until a complete packet is buffered, so a stalled tile cannot block a router port mid-packet.
- Instantiated NODES times at the MPSoC top, between the tile link_out and the mesh link_out wires.

---
 rtl/msp430_noc_link_buffer_pkg.sv | 13 +
 rtl/msp430_noc_link_buffer_channel.sv | 86 ++++++++
 rtl/msp430_noc_link_buffer.sv | 44 ++++
 tb/tb_msp430_noc_link_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/msp430_noc_link_buffer_pkg.sv
// Shared defaults for the NoC link buffer: link geometry and the default per-channel depth.
package msp430_noc_link_buffer_pkg;

    localparam int unsigned NOC_FLIT_WIDTH_DEF = 32;
    localparam int unsigned NOC_CHANNELS_DEF   = 2;
    localparam int unsigned LINK_BUFFER_DEPTH  = 4;

    // One extra MSB above the index bits distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/msp430_noc_link_buffer_channel.sv
// One virtual-channel FIFO of the link buffer.
// Also holds the complete-packet counter and the optional full-packet gating of out_valid.
module msp430_noc_link_buffer_channel
    import msp430_noc_link_buffer_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter bit          FULLPACKET = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_WIDTH-1:0]        in_flit,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [FLIT_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic                ready_q;

    logic                empty, full, wr_en, rd_en;
    logic [FLIT_WIDTH:0] head;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // ready_q keeps in_ready low during reset and for the release edge itself.
    assign in_ready = ready_q && !full;
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = out_valid && out_ready;

    always_comb begin
        out_valid = !empty;
        if (FULLPACKET)
            out_valid = !empty && ((pkt_cnt_q != '0) || full);
    end

    assign out_flit   = out_valid ? head[FLIT_WIDTH-1:0] : '0;
    assign out_last   = out_valid ? head[FLIT_WIDTH] : 1'b0;
    assign fill_level = CW'(wr_ptr_q - rd_ptr_q);

    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({wr_en && in_last, rd_en && head[FLIT_WIDTH]})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Storage is not reset: clearing the pointers is enough to discard held flits.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_flit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            ready_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/msp430_noc_link_buffer.sv
// Per-tile elastic flit buffer between tile NoC output and router input.
// One independent FIFO per virtual channel; no arbitration between channels.
module msp430_noc_link_buffer
    import msp430_noc_link_buffer_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = NOC_FLIT_WIDTH_DEF,
    parameter int unsigned CHANNELS   = NOC_CHANNELS_DEF,
    parameter int unsigned DEPTH      = LINK_BUFFER_DEPTH,
    parameter bit          FULLPACKET = 1'b0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]       in_flit,
    input  logic [CHANNELS-1:0]                       in_last,
    input  logic [CHANNELS-1:0]                       in_valid,
    output logic [CHANNELS-1:0]                       in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]       out_flit,
    output logic [CHANNELS-1:0]                       out_last,
    output logic [CHANNELS-1:0]                       out_valid,
    input  logic [CHANNELS-1:0]                       out_ready,
    output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]  fill_level
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        msp430_noc_link_buffer_channel #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (DEPTH),
            .FULLPACKET (FULLPACKET)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .in_flit    (in_flit[gi]),
            .in_last    (in_last[gi]),
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .out_flit   (out_flit[gi]),
            .out_last   (out_last[gi]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .fill_level (fill_level[gi])
        );
    end

endmodule

// File: tb/tb_msp430_noc_link_buffer.sv
// Directed bench: dut_a streams flits without gating, dut_b holds each packet until it is complete.
module tb_msp430_noc_link_buffer;

    localparam int FW = 32;
    localparam int CH = 2;
    localparam int DP = 4;
    localparam int LW = $clog2(DP + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH-1:0][FW-1:0] a_in_flit, a_out_flit, b_in_flit, b_out_flit;
    logic [CH-1:0] a_in_last, a_in_valid, a_in_ready, a_out_last, a_out_valid, a_out_ready;
    logic [CH-1:0] b_in_last, b_in_valid, b_in_ready, b_out_last, b_out_valid, b_out_ready;
    logic [CH-1:0][LW-1:0] a_fill, b_fill;

    int n_tests = 0;
    int n_fail  = 0;

    msp430_noc_link_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP), .FULLPACKET(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .in_flit(a_in_flit), .in_last(a_in_last), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_flit(a_out_flit), .out_last(a_out_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .fill_level(a_fill)
    );

    msp430_noc_link_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP), .FULLPACKET(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .in_flit(b_in_flit), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_flit(b_out_flit), .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .fill_level(b_fill)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_in_flit = '0; a_in_last = '0; a_in_valid = '0; a_out_ready = '0;
        b_in_flit = '0; b_in_last = '0; b_in_valid = '0; b_out_ready = '0;

        // 1: reset and release
        tick(); tick();
        chk_eq("rst_in_ready_a", 64'(a_in_ready), 64'h0);
        chk_eq("rst_in_ready_b", 64'(b_in_ready), 64'h0);
        chk_eq("rst_out_valid", 64'({a_out_valid, b_out_valid}), 64'h0);
        chk_eq("rst_out_flit", 64'(a_out_flit[0]), 64'h0);
        chk_eq("rst_fill", 64'({a_fill, b_fill}), 64'h0);
        #4 rst = 1'b0;
        #1 chk_eq("release_in_ready_pre", 64'(a_in_ready), 64'h0);
        tick();
        chk_eq("release_in_ready_a", 64'(a_in_ready), 64'h3);
        chk_eq("release_in_ready_b", 64'(b_in_ready), 64'h3);

        // 2: single flit, no bypass when empty
        a_in_flit[0] = 32'hDEADBEEF; a_in_last[0] = 1'b1; a_in_valid[0] = 1'b1;
        #1 chk_eq("single_no_bypass", 64'(a_out_valid[0]), 64'h0);
        tick();
        a_in_valid[0] = 1'b0; a_in_last[0] = 1'b0;
        chk_eq("single_valid", 64'(a_out_valid), 64'h1);
        chk_eq("single_flit", 64'(a_out_flit[0]), 64'hDEADBEEF);
        chk_eq("single_last", 64'(a_out_last[0]), 64'h1);
        chk_eq("single_ch1_flit", 64'(a_out_flit[1]), 64'h0);
        a_out_ready[0] = 1'b1;
        tick();
        a_out_ready[0] = 1'b0;
        chk_eq("single_drained", 64'(a_out_valid[0]), 64'h0);
        chk_eq("single_fill0", 64'(a_fill[0]), 64'h0);

        // 3: fill to full, then read with a blocked write
        for (int i = 1; i <= 4; i++) begin
            a_in_flit[0] = 32'(i); a_in_valid[0] = 1'b1;
            tick();
        end
        chk_eq("full_in_ready", 64'(a_in_ready[0]), 64'h0);
        chk_eq("full_fill", 64'(a_fill[0]), 64'h4);
        chk_eq("full_head", 64'(a_out_flit[0]), 64'h1);
        a_in_flit[0] = 32'h5; a_out_ready[0] = 1'b1;
        tick();
        a_in_valid[0] = 1'b0; a_out_ready[0] = 1'b0;
        chk_eq("full_read_in_ready", 64'(a_in_ready[0]), 64'h1);
        chk_eq("full_read_fill", 64'(a_fill[0]), 64'h3);
        chk_eq("full_read_head", 64'(a_out_flit[0]), 64'h2);
        a_out_ready[0] = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            chk_eq($sformatf("drain_head%0d", i), 64'(a_out_flit[0]), 64'(i));
            tick();
        end
        chk_eq("drain_empty", 64'(a_out_valid[0]), 64'h0);
        chk_eq("drain_fill", 64'(a_fill[0]), 64'h0);

        // 4: streaming 16 flits at one per cycle
        for (int i = 0; i < 16; i++) begin
            a_in_flit[0] = 32'(i); a_in_last[0] = (i == 15); a_in_valid[0] = 1'b1;
            tick();
            chk_eq($sformatf("stream_head%0d", i), 64'({a_out_valid[0], a_out_last[0], a_out_flit[0]}),
                   64'({1'b1, (i == 15), 32'(i)}));
            chk_eq($sformatf("stream_fill%0d", i), 64'(a_fill[0]), 64'h1);
        end
        a_in_valid[0] = 1'b0; a_in_last[0] = 1'b0;
        tick();
        a_out_ready[0] = 1'b0;
        chk_eq("stream_done_fill", 64'(a_fill[0]), 64'h0);

        // 5a: full-packet gating of a 3-flit packet with a gap
        b_out_ready[0] = 1'b1;
        b_in_flit[0] = 32'hA; b_in_valid[0] = 1'b1;
        tick();
        chk_eq("fp_after_A", 64'(b_out_valid[0]), 64'h0);
        b_in_flit[0] = 32'hB;
        tick();
        b_in_valid[0] = 1'b0;
        chk_eq("fp_after_B", 64'(b_out_valid[0]), 64'h0);
        tick();
        chk_eq("fp_gap1", 64'(b_out_valid[0]), 64'h0);
        tick();
        chk_eq("fp_gap2", 64'(b_out_valid[0]), 64'h0);
        chk_eq("fp_gap_fill", 64'(b_fill[0]), 64'h2);
        b_in_flit[0] = 32'hC; b_in_last[0] = 1'b1; b_in_valid[0] = 1'b1;
        #1 chk_eq("fp_C_same_cycle", 64'(b_out_valid[0]), 64'h0);
        tick();
        b_in_valid[0] = 1'b0; b_in_last[0] = 1'b0;
        chk_eq("fp_out_A", 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}), 64'({1'b1, 1'b0, 32'hA}));
        tick();
        chk_eq("fp_out_B", 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}), 64'({1'b1, 1'b0, 32'hB}));
        tick();
        chk_eq("fp_out_C", 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}), 64'({1'b1, 1'b1, 32'hC}));
        tick();
        b_out_ready[0] = 1'b0;
        chk_eq("fp_done", 64'({b_out_valid[0], b_fill[0]}), 64'h0);

        // 5b: 5-flit packet with DEPTH 4 released by the full override
        for (int i = 1; i <= 4; i++) begin
            b_in_flit[0] = 32'(i); b_in_valid[0] = 1'b1;
            tick();
            chk_eq($sformatf("fp5_valid%0d", i), 64'(b_out_valid[0]), 64'((i == 4) ? 1 : 0));
        end
        b_in_flit[0] = 32'h5; b_in_last[0] = 1'b1; b_out_ready[0] = 1'b1;
        tick();
        b_out_ready[0] = 1'b0;
        chk_eq("fp5_gate_again", 64'(b_out_valid[0]), 64'h0);
        chk_eq("fp5_in_ready", 64'(b_in_ready[0]), 64'h1);
        tick();
        b_in_valid[0] = 1'b0; b_in_last[0] = 1'b0;
        chk_eq("fp5_complete", 64'({b_out_valid[0], b_fill[0]}), 64'({1'b1, 3'd4}));
        b_out_ready[0] = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk_eq($sformatf("fp5_out%0d", i), 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}),
                   64'({1'b1, (i == 5), 32'(i)}));
            tick();
        end
        b_out_ready[0] = 1'b0;
        chk_eq("fp5_empty", 64'(b_out_valid[0]), 64'h0);

        // 6: asynchronous reset with a partial packet buffered
        for (int i = 0; i < 2; i++) begin
            a_in_flit[0] = 32'h11 * 32'(i + 1); a_in_valid[0] = 1'b1;
            b_in_flit[0] = 32'h11 * 32'(i + 1); b_in_valid[0] = 1'b1;
            tick();
        end
        a_in_valid[0] = 1'b0; b_in_valid[0] = 1'b0;
        chk_eq("partial_fill", 64'({a_fill[0], b_fill[0]}), 64'({3'd2, 3'd2}));
        chk_eq("partial_b_gated", 64'(b_out_valid[0]), 64'h0);
        #2 rst = 1'b1;
        #1 chk_eq("async_valid", 64'({a_out_valid, b_out_valid}), 64'h0);
        chk_eq("async_flit", 64'(a_out_flit[0]), 64'h0);
        chk_eq("async_fill", 64'({a_fill, b_fill}), 64'h0);
        chk_eq("async_in_ready", 64'({a_in_ready, b_in_ready}), 64'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk_eq("rerelease_in_ready", 64'({a_in_ready, b_in_ready}), 64'hF);
        for (int i = 0; i < 2; i++) begin
            a_in_flit[0] = 32'h77 + 32'(i * 17); a_in_last[0] = (i == 1); a_in_valid[0] = 1'b1;
            b_in_flit[0] = 32'h77 + 32'(i * 17); b_in_last[0] = (i == 1); b_in_valid[0] = 1'b1;
            tick();
        end
        a_in_valid[0] = 1'b0; a_in_last[0] = 1'b0; b_in_valid[0] = 1'b0; b_in_last[0] = 1'b0;
        chk_eq("fresh_fill", 64'({a_fill[0], b_fill[0]}), 64'({3'd2, 3'd2}));
        chk_eq("fresh_a_head", 64'({a_out_valid[0], a_out_last[0], a_out_flit[0]}), 64'({1'b1, 1'b0, 32'h77}));
        chk_eq("fresh_b_head", 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}), 64'({1'b1, 1'b0, 32'h77}));
        a_out_ready[0] = 1'b1; b_out_ready[0] = 1'b1;
        tick();
        chk_eq("fresh_a_tail", 64'({a_out_valid[0], a_out_last[0], a_out_flit[0]}), 64'({1'b1, 1'b1, 32'h88}));
        chk_eq("fresh_b_tail", 64'({b_out_valid[0], b_out_last[0], b_out_flit[0]}), 64'({1'b1, 1'b1, 32'h88}));
        tick();
        chk_eq("fresh_empty", 64'({a_out_valid, b_out_valid, a_fill, b_fill}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
